// File: rtl/player_motion_ctrl.sv
// Player sprite controller: jump arc, clamped walking, airborne flag and sprite-table word.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra jump while airborne).
module player_motion_ctrl #(
    parameter int unsigned START_X   = 80,
    parameter int unsigned GROUND_Y  = 350,
    parameter int unsigned MIN_Y     = 32,
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = 608,
    parameter int unsigned H_PERIOD  = 400000,
    parameter int unsigned T_START   = 100000,
    parameter int unsigned T_STEP    = 10000,
    parameter int unsigned T_MAX     = 800000,
    parameter int unsigned T_TERM    = 250000,
    parameter int unsigned TW        = 20,
    parameter logic [4:0]  SPRITE_ID = 5'b10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up,
    input  logic        left,
    input  logic        right,
    input  logic        game_over,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        airborne,
    output logic [31:0] dina,
    output logic [2:0]  addr
);

    localparam int unsigned PW = 10;
    localparam int unsigned HW = (H_PERIOD > 1) ? $clog2(H_PERIOD) : 1;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] x_q, x_d;
    logic [PW-1:0] y_q, y_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] period_q, period_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic          up_q;
    logic          airborne_q, airborne_d;
    logic          up_edge;
    logic [TW-1:0] fall_period;
    logic [2:0]    row_c, col_c;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic          dj_used_q, dj_used_d;
`endif

    assign up_edge = up & ~up_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_GROUND;
            x_q        <= PW'(START_X);
            y_q        <= PW'(GROUND_Y);
            timer_q    <= '0;
            period_q   <= '0;
            h_cnt_q    <= '0;
            up_q       <= 1'b0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            timer_q    <= timer_d;
            period_q   <= period_d;
            h_cnt_q    <= h_cnt_d;
            up_q       <= up;
            airborne_q <= airborne_d;
        end
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dj_used_q <= 1'b0;
        end else begin
            dj_used_q <= dj_used_d;
        end
    end
`endif

    // Horizontal walk: one step per H_PERIOD cycles while exactly one direction is held.
    always_comb begin
        h_cnt_d = h_cnt_q;
        x_d     = x_q;
        if (!game_over) begin
            if (left ^ right) begin
                if (h_cnt_q == HW'(H_PERIOD - 1)) begin
                    h_cnt_d = '0;
                    if (right && (x_q < PW'(X_MAX))) begin
                        x_d = x_q + PW'(1);
                    end else if (left && (x_q > PW'(X_MIN))) begin
                        x_d = x_q - PW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
            end else begin
                h_cnt_d = '0;
            end
        end
    end

    // Vertical arc: a step fires when the timer has counted down to zero.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        timer_d     = timer_q;
        period_d    = period_q;
        fall_period = period_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_used_d   = dj_used_q;
`endif
        if (!game_over) begin
            case (state_q)
                ST_GROUND: begin
                    if (up_edge) begin
                        state_d  = ST_RISE;
                        period_d = TW'(T_START);
                        timer_d  = TW'(T_START);
                    end
                end
                ST_RISE: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else begin
                        if (y_q > PW'(MIN_Y)) begin
                            y_d = y_q - PW'(1);
                        end
                        if (period_q <= TW'(T_MAX)) begin
                            period_d = period_q + TW'(T_STEP);
                            timer_d  = period_q + TW'(T_STEP);
                        end else begin
                            state_d  = ST_FALL;
                            period_d = TW'(T_MAX);
                            timer_d  = TW'(T_MAX);
                        end
                    end
                end
                ST_FALL: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else if (({1'b0, y_q} + 11'd1) >= 11'(GROUND_Y)) begin
                        y_d     = PW'(GROUND_Y);
                        state_d = ST_GROUND;
                        timer_d = '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                        dj_used_d = 1'b0;
`endif
                    end else begin
                        y_d = y_q + PW'(1);
                        if (period_q > TW'(T_TERM)) begin
                            fall_period = period_q - TW'(T_STEP);
                        end
                        period_d = fall_period;
                        timer_d  = fall_period;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                end
            endcase
`ifdef PLAYER_DOUBLE_JUMP_EN
            // The extra jump overrides whatever step fires in the same cycle.
            if (up_edge && (state_q != ST_GROUND) && !dj_used_q) begin
                state_d   = ST_RISE;
                period_d  = TW'(T_START);
                timer_d   = TW'(T_START);
                dj_used_d = 1'b1;
            end
`endif
        end
        airborne_d = (state_d != ST_GROUND);
    end

    // Sprite frame selection; the freeze pose wins over the arc pose.
    always_comb begin
        row_c = 3'd0;
        col_c = 3'd0;
        if (game_over) begin
            row_c = 3'd1;
        end else if (state_q == ST_RISE) begin
            col_c = 3'd1;
        end else if (state_q == ST_FALL) begin
            row_c = 3'd1;
            col_c = 3'd1;
        end
    end

    assign pos_x    = x_q;
    assign pos_y    = y_q;
    assign airborne = airborne_q;
    assign dina     = {SPRITE_ID, 1'b0, x_q, y_q, row_c, col_c};
    assign addr     = 3'd0;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: per-cycle behavioural model comparison plus hand-computed arc checks.
module tb_player_motion_ctrl;

    localparam int unsigned START_X  = 81;
    localparam int unsigned GROUND_Y = 20;
    localparam int unsigned MIN_Y    = 10;
    localparam int unsigned X_MIN    = 78;
    localparam int unsigned X_MAX    = 82;
    localparam int unsigned H_PERIOD = 3;
    localparam int unsigned T_START  = 4;
    localparam int unsigned T_STEP   = 2;
    localparam int unsigned T_MAX    = 10;
    localparam int unsigned T_TERM   = 4;

    logic        clk = 1'b0;
    logic        reset, up, left, right, game_over;
    logic [9:0]  pos_x, pos_y;
    logic        airborne;
    logic [31:0] dina;
    logic [2:0]  addr;

    always #5 clk = ~clk;

    player_motion_ctrl #(
        .START_X(START_X), .GROUND_Y(GROUND_Y), .MIN_Y(MIN_Y), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .H_PERIOD(H_PERIOD), .T_START(T_START), .T_STEP(T_STEP), .T_MAX(T_MAX),
        .T_TERM(T_TERM), .TW(8), .SPRITE_ID(5'b10000)
    ) dut (
        .clk(clk), .reset(reset), .up(up), .left(left), .right(right),
        .game_over(game_over), .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne),
        .dina(dina), .addr(addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: mode 0 = on ground, 1 = going up, 2 = coming down; cycles_left counts down to the next step.
    int m_x, m_y, m_mode, m_per, m_cycles_left, m_walk;
    bit m_up_prev, m_dj;

    task automatic m_reset();
        m_x = START_X; m_y = GROUND_Y; m_mode = 0; m_per = 0;
        m_cycles_left = 0; m_walk = 0; m_up_prev = 1'b0; m_dj = 1'b0;
    endtask

    task automatic m_launch();
        m_mode = 1; m_per = T_START; m_cycles_left = T_START + 1;
    endtask

    task automatic m_tick();
        bit jump;
        int was;
        jump = up && !m_up_prev;
        m_up_prev = up;
        if (reset) begin
            m_reset();
            return;
        end
        if (game_over) return;
        if (left != right) begin
            m_walk++;
            if (m_walk == H_PERIOD) begin
                m_walk = 0;
                if (right) m_x = (m_x + 1 > X_MAX) ? X_MAX : m_x + 1;
                else       m_x = (m_x - 1 < X_MIN) ? X_MIN : m_x - 1;
            end
        end else begin
            m_walk = 0;
        end
        was = m_mode;
        if (was == 0) begin
            if (jump) m_launch();
        end else begin
            m_cycles_left--;
            if (m_cycles_left == 0) begin
                if (was == 1) begin
                    if (m_y > MIN_Y) m_y--;
                    if (m_per <= T_MAX) m_per += T_STEP;
                    else begin m_mode = 2; m_per = T_MAX; end
                    m_cycles_left = m_per + 1;
                end else if (m_y + 1 >= GROUND_Y) begin
                    m_y = GROUND_Y; m_mode = 0; m_dj = 1'b0;
                end else begin
                    m_y++;
                    if (m_per > T_TERM) m_per -= T_STEP;
                    m_cycles_left = m_per + 1;
                end
            end
`ifdef PLAYER_DOUBLE_JUMP_EN
            if (jump && !m_dj) begin
                m_launch();
                m_dj = 1'b1;
            end
`endif
        end
    endtask

    function automatic logic [31:0] m_dina();
        logic [2:0] r, c;
        r = (game_over || m_mode == 2) ? 3'd1 : 3'd0;
        c = (!game_over && m_mode != 0) ? 3'd1 : 3'd0;
        return {5'b10000, 1'b0, 10'(m_x), 10'(m_y), r, c};
    endfunction

    always @(negedge clk) begin
        chk("pos_x", 32'(pos_x), 32'(m_x));
        chk("pos_y", 32'(pos_y), 32'(m_y));
        chk("airborne", 32'(airborne), 32'(m_mode != 0));
        chk("dina", dina, m_dina());
        chk("addr", 32'(addr), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        m_tick();
        #1;
    endtask

    task automatic wait_ground(input string name, input int bound);
        int n;
        n = 0;
        while (airborne && n < bound) begin
            tick();
            n++;
        end
        chk(name, 32'(airborne), 32'd0);
    endtask

    int exp_y[10]  = '{19, 18, 17, 16, 15, 16, 17, 18, 19, 20};
    int exp_dt[10] = '{5, 7, 9, 11, 13, 11, 9, 7, 5, 5};

    initial begin
        int cnt, prev_y, jumps;
        bit prev_air;
        reset = 1'b1; up = 1'b0; left = 1'b0; right = 1'b0; game_over = 1'b0;
        m_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset asserted in the middle of a jump
        up = 1'b1; tick(); up = 1'b0;
        repeat (12) tick();
        chk("mid_jump_air", 32'(airborne), 32'd1);
        reset = 1'b1;
        m_reset();
        #1;
        chk("rst_pos_y", 32'(pos_y), 32'd20);
        chk("rst_pos_x", 32'(pos_x), 32'd81);
        chk("rst_airborne", 32'(airborne), 32'd0);
        chk("rst_sprite_id", 32'(dina[31:27]), 32'h10);
        chk("rst_rowcol", 32'(dina[5:0]), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Full arc from a single pulse: Y value and cycle interval of every step
        up = 1'b1; tick(); up = 1'b0;
        prev_y = int'(pos_y);
        for (int i = 0; i < 10; i++) begin
            cnt = 0;
            while (int'(pos_y) == prev_y && cnt < 40) begin
                tick();
                cnt++;
            end
            chk($sformatf("arc_y%0d", i), 32'(pos_y), 32'(exp_y[i]));
            chk($sformatf("arc_dt%0d", i), 32'(cnt), 32'(exp_dt[i]));
            if (i == 4) chk("apex_fall_frame", 32'(dina[5:0]), 32'b001001);
            prev_y = int'(pos_y);
        end
        chk("arc_landed", 32'(airborne), 32'd0);

        // Held button produces exactly one jump
        jumps = 0;
        prev_air = airborne;
        up = 1'b1;
        repeat (100) begin
            tick();
            if (airborne && !prev_air) jumps++;
            prev_air = airborne;
        end
        chk("held_jumps", 32'(jumps), 32'd1);
        chk("held_landed", 32'(airborne), 32'd0);
        up = 1'b0;
        tick();

        // Walking and clamps
        right = 1'b1;
        repeat (3) tick();
        chk("walk_right_step", 32'(pos_x), 32'd82);
        repeat (6) tick();
        chk("walk_right_clamp", 32'(pos_x), 32'd82);
        left = 1'b1;
        repeat (6) tick();
        chk("walk_both_hold", 32'(pos_x), 32'd82);
        right = 1'b0;
        repeat (9) tick();
        chk("walk_left_3", 32'(pos_x), 32'd79);
        repeat (6) tick();
        chk("walk_left_clamp", 32'(pos_x), 32'd78);
        left = 1'b0;
        tick();

        // Freeze in the middle of the rise, then resume from the frozen timer
        up = 1'b1; tick(); up = 1'b0;
        repeat (8) tick();
        chk("pre_freeze_y", 32'(pos_y), 32'd19);
        game_over = 1'b1;
        right = 1'b1;
        repeat (50) tick();
        chk("frozen_y", 32'(pos_y), 32'd19);
        chk("frozen_x", 32'(pos_x), 32'd78);
        chk("frozen_frame", 32'(dina[5:0]), 32'b001000);
        game_over = 1'b0;
        right = 1'b0;
        repeat (3) tick();
        chk("resume_hold_y", 32'(pos_y), 32'd19);
        tick();
        chk("resume_step_y", 32'(pos_y), 32'd18);
        wait_ground("freeze_land_timeout", 300);

        // Second press at the apex
        up = 1'b1; tick(); up = 1'b0;
        cnt = 0;
        while (dina[5:0] != 6'b001001 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("apex_reached_y", 32'(pos_y), 32'd15);
        tick();
        up = 1'b1; tick();
`ifdef PLAYER_DOUBLE_JUMP_EN
        chk("dj_rise_frame", 32'(dina[5:0]), 32'b000001);
        up = 1'b0; tick();
        up = 1'b1; tick();
        up = 1'b0; tick(); tick();
        chk("dj_third_hold_y", 32'(pos_y), 32'd15);
        tick();
        chk("dj_first_step_y", 32'(pos_y), 32'd14);
`else
        chk("nodj_fall_frame", 32'(dina[5:0]), 32'b001001);
        chk("nodj_airborne", 32'(airborne), 32'd1);
`endif
        up = 1'b0;
        wait_ground("dj_land_timeout", 500);
        up = 1'b1; tick(); up = 1'b0;
        chk("rejump_after_land", 32'(airborne), 32'd1);
        wait_ground("rejump_land_timeout", 300);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
